// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator: one load/store at a time, byte-lane masks, load extension
// Optional alignment checking is enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [3:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [3:0]        mem_ctrl,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_available
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

  state_t      state;
  logic [1:0]  lat_off;
  logic [2:0]  lat_ctrl;
  logic        size_none;
  logic        misalign;
  logic        req_err;
  logic        accept;
  logic [1:0]  eff_off;
  logic [3:0]  lane_mask;
  logic [31:0] store_data;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Size decode: word wins over half wins over byte; the lane offset is
  // normalised here so the load path only needs the latched offset.
  always_comb begin
    size_none = ~|req_ctrl[2:0];
    misalign  = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (req_ctrl[2])
      misalign = |req_addr[1:0];
    else if (req_ctrl[1])
      misalign = req_addr[0];
`endif
    req_err = size_none | misalign;

    if (req_ctrl[2]) begin
      eff_off    = 2'b00;
      lane_mask  = 4'b1111;
      store_data = req_wdata;
    end else if (req_ctrl[1]) begin
      eff_off    = {req_addr[1], 1'b0};
      lane_mask  = 4'b0011 << {req_addr[1], 1'b0};
      store_data = {2{req_wdata[15:0]}};
    end else begin
      eff_off    = req_addr[1:0];
      lane_mask  = 4'b0001 << req_addr[1:0];
      store_data = {4{req_wdata[7:0]}};
    end
  end

  assign req_ready   = (state == IDLE) && mem_available && !rst;
  assign accept      = req_valid && req_ready;
  assign mem_wr_en   = accept && req_we && !req_err;
  assign mem_rd_en   = accept && !req_we && !req_err;
  assign mem_ctrl    = mem_wr_en ? lane_mask : 4'b0000;
  assign mem_address = req_addr;
  assign mem_wdata   = store_data;

  assign shifted = mem_rdata >> {lat_off, 3'b000};

  always_comb begin
    if (lat_ctrl[1])
      load_data = shifted;
    else if (lat_ctrl[0])
      load_data = {{16{lat_ctrl[2] & shifted[15]}}, shifted[15:0]};
    else
      load_data = {{24{lat_ctrl[2] & shifted[7]}}, shifted[7:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      lat_off    <= 2'b00;
      lat_ctrl   <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (accept) begin
            if (req_err || req_we) begin
              resp_err   <= req_err;
              resp_rdata <= 32'h0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              lat_off  <= eff_off;
              lat_ctrl <= {req_ctrl[3], req_ctrl[2], req_ctrl[1]};
              state    <= LOAD_WAIT;
            end
          end
        end
        LOAD_WAIT: begin
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_ctrl = 4'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [3:0]  mem_ctrl;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_available = 1'b1;

  logic [31:0] mem [0:255];
  int checks = 0;
  int failures = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_ctrl(mem_ctrl),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_available(mem_available)
  );

  always #5 clk = ~clk;

  // Byte-masked word memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_ctrl[b]) mem[mem_address[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_rd_en) mem_rdata <= mem[mem_address[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic we, input logic [3:0] ctrl,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_wr, input logic exp_rd, input logic [3:0] exp_mask,
                        input logic [31:0] exp_wd, input int lat,
                        input logic [31:0] exp_data, input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
    #1;
    check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, ".wr_en"}, {31'b0, mem_wr_en}, {31'b0, exp_wr});
    check({tag, ".rd_en"}, {31'b0, mem_rd_en}, {31'b0, exp_rd});
    check({tag, ".mask"}, {28'b0, mem_ctrl}, {28'b0, exp_mask});
    if (exp_wr) check({tag, ".wdata"}, mem_wdata, exp_wd);
    @(negedge clk);
    req_valid = 1'b0;
    if (lat == 2) begin
      check({tag, ".early"}, {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    check({tag, ".valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, ".rdata"}, resp_rdata, exp_data);
    check({tag, ".err"}, {31'b0, resp_err}, {31'b0, exp_err});
    @(negedge clk);
    check({tag, ".pulse"}, {31'b0, resp_valid}, 32'd0);
    check({tag, ".hold"}, resp_rdata, exp_data);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h8899AABB;

    // Reset state, with a request pending to confirm strobes stay low.
    req_valid = 1'b1; req_ctrl = 4'b0100; req_addr = 32'h100;
    #12;
    check("rst.valid", {31'b0, resp_valid}, 32'd0);
    check("rst.rdata", resp_rdata, 32'h0);
    check("rst.err", {31'b0, resp_err}, 32'd0);
    check("rst.ready", {31'b0, req_ready}, 32'd0);
    check("rst.rd_en", {31'b0, mem_rd_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("post_rst.ready", {31'b0, req_ready}, 32'd1);

    access("ld_sb_101", 1'b0, 4'b1001, 32'h101, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2, 32'hFFFFFFAA, 1'b0);
    access("ld_uh_102", 1'b0, 4'b0010, 32'h102, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2, 32'h00008899, 1'b0);
    access("st_h_102", 1'b1, 4'b0010, 32'h102, 32'hDEAD1234, 1'b1, 1'b0, 4'b1100, 32'h12341234, 1, 32'h0, 1'b0);
    access("ld_w_100", 1'b0, 4'b0100, 32'h100, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2, 32'h1234AABB, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    access("ld_w_101", 1'b0, 4'b0100, 32'h101, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1, 32'h0, 1'b1);
    access("ld_h_107", 1'b0, 4'b1010, 32'h107, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1, 32'h0, 1'b1);
`else
    access("ld_w_101", 1'b0, 4'b0100, 32'h101, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2, 32'h1234AABB, 1'b0);
    access("ld_h_103", 1'b0, 4'b1010, 32'h103, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2, 32'h00001234, 1'b0);
`endif
    access("ld_nosize", 1'b0, 4'b1000, 32'h100, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1, 32'h0, 1'b1);
    access("st_nosize", 1'b1, 4'b0000, 32'h100, 32'h55, 1'b0, 1'b0, 4'h0, 32'h0, 1, 32'h0, 1'b1);
    access("st_b_103", 1'b1, 4'b0001, 32'h103, 32'h00000077, 1'b1, 1'b0, 4'b1000, 32'h77777777, 1, 32'h0, 1'b0);
    access("ld_sh_100", 1'b0, 4'b1010, 32'h100, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2, 32'hFFFFAABB, 1'b0);
    access("ld_sb_103", 1'b0, 4'b1001, 32'h103, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2, 32'h00000077, 1'b0);
    access("st_w_104", 1'b1, 4'b0100, 32'h104, 32'hCAFEF00D, 1'b1, 1'b0, 4'b1111, 32'hCAFEF00D, 1, 32'h0, 1'b0);
    access("ld_ub_105", 1'b0, 4'b0001, 32'h105, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2, 32'h000000F0, 1'b0);
    access("ld_sh_106", 1'b0, 4'b1010, 32'h106, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2, 32'hFFFFCAFE, 1'b0);

    // Reset while a load is in LOAD_WAIT drops its response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_ctrl = 4'b0100; req_addr = 32'h104;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rstw.valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstw.ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstw.no_resp", {31'b0, resp_valid}, 32'd0);
    end

    // Memory not available: request is held, nothing strobes.
    mem_available = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_ctrl = 4'b0001; req_addr = 32'h108; req_wdata = 32'h5A;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("avail.ready", {31'b0, req_ready}, 32'd0);
      check("avail.strobe", {30'b0, mem_wr_en, mem_rd_en}, 32'd0);
      @(negedge clk);
    end
    mem_available = 1'b1;
    #1;
    check("avail.accept", {31'b0, req_ready & mem_wr_en}, 32'd1);
    check("avail.mask", {28'b0, mem_ctrl}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    check("avail.valid", {31'b0, resp_valid}, 32'd1);
    @(negedge clk);
    access("ld_w_108", 1'b0, 4'b0100, 32'h108, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 2, 32'h0000005A, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's data-memory port. Accepts one load or store at a time from the execute stage and drives the word-addressed, byte-masked, one-cycle-read-latency data memory. Returns aligned, zero- or sign-extended load data. Computes byte-lane write masks and lane-replicated store data. Flags misaligned or malformed accesses without touching memory.

## Interface
Parameters:
- ADDR_W, 32, byte-address width presented to memory.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_ctrl  in  4  [3]=sign-extend, [2]=word, [1]=half, [0]=byte
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  access rejected (misaligned or no size bit)
- mem_wr_en  out  1  memory write strobe
- mem_rd_en  out  1  memory read strobe
- mem_ctrl  out  4  byte-lane write mask
- mem_address  out  ADDR_W  byte address; memory uses [ADDR_W-1:2]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read word, valid the cycle after mem_rd_en
- mem_available  in  1  memory ready; low after memory reset

## Operation
- States: IDLE, LOAD_WAIT, RESP.
- req_ready = (state==IDLE) && mem_available && !rst.
- Size decode priority: word > half > byte. No size bit set → error.
- Store acceptance in IDLE:
  - mem_wr_en=1 combinationally in the same cycle.
  - mem_ctrl: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],0}; word = 4'b1111.
  - mem_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
  - Next state RESP.
- Load acceptance in IDLE:
  - mem_rd_en=1 in the same cycle, with mem_ctrl=0.
  - Latch addr[1:0] and ctrl.
  - Next state LOAD_WAIT.
- LOAD_WAIT:
  - Shift mem_rdata right by 8*addr[1:0].
  - Keep 8, 16 or 32 bits; sign-extend if ctrl[3], else zero-extend.
  - Register the result into resp_rdata. Next state RESP.
- Error acceptance: no memory strobe, resp_err registered to 1, resp_rdata=0. Next state RESP.
- RESP: resp_valid=1 for exactly one cycle. Next state IDLE. resp_err/resp_rdata hold until the next response.
- mem_address = req_addr (pass-through). mem_wr_en and mem_rd_en are gated to the accepting cycle only.
- Responses have no backpressure; the pipeline must sample the resp_valid pulse.

## Timing
- Reset (async): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
- Strobes are 0 while rst is high.
- Acceptance at cycle T:
  - Store: resp_valid at T+1.
  - Load: resp_valid at T+2.
  - Error: resp_valid at T+1.
- Throughput: one request per 2 cycles for stores and errors, per 3 cycles for loads.
- mem_available low: req_ready=0, request held by pipeline. An in-flight load still completes.
- rst asserted in LOAD_WAIT or RESP: the pending response is dropped and resp_valid never pulses for it.
- Store-then-load to the same word: the load is accepted at T+2 or later and returns the stored bytes (the write commits at the end of T).

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - Error on half with addr[0]=1.
  - Error on word with addr[1:0]≠0.
- LSU_MISALIGN_CHECK_EN undefined:
  - No alignment check.
  - Half uses addr[1] only; word ignores addr[1:0].
  - resp_err asserts only for the no-size-bit case.

## Test plan
- Memory word 0x100 = 0x8899AABB; load ctrl=4'b1001 (signed byte) at addr 0x101 → no resp at T+1; resp_valid at T+2, resp_rdata=0xFFFFFFAA, resp_err=0.
- Same word; load ctrl=4'b0010 (unsigned half) at addr 0x102 → resp_rdata=0x00008899 at T+2.
- Store ctrl=4'b0010, addr 0x102, wdata 0xDEAD1234 → at T: mem_wr_en=1, mem_ctrl=4'b1100, mem_wdata=0x12341234; resp_valid at T+1. A following word load at 0x100 returns 0x1234AABB.
- With macro: load word at addr 0x101 → mem_rd_en stays 0; resp_valid=1, resp_err=1, resp_rdata=0 at T+1. Without macro: resp_err=0 and data = word at 0x100.
- Assert rst for 1 cycle during LOAD_WAIT → resp_valid never pulses for that load; req_ready returns to 1 the first cycle after rst falls with mem_available=1.
- Hold mem_available=0 with req_valid=1 for 3 cycles → req_ready=0 and no strobes; on mem_available=1 the request is accepted that cycle.
